// File: rtl/collision_detector.sv
// -----------------------------------------------------------------------------
// collision_detector
//
// Checks the dinosaur bounding box against up to NUM_OBS obstacle boxes once
// per qualifying animation frame. On a qualifying strobe in RUN, the dino box
// and every obstacle slot are captured into registers. The block then walks the
// slots one per clock. The first strict overlap ends the game. A clean walk
// through all slots bumps the survived-frame score. After reset or restart, a
// grace window of GRACE_FRAMES qualifying strobes passes with no checking.
//
// Parameters
//   NUM_OBS       obstacle slots scanned per frame (1..8)
//   GRACE_FRAMES  qualifying strobes ignored after reset/restart (0..255)
//   SCORE_W       score counter width
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_ani_stb, i_animate  frame strobe and its qualifier
//   i_restart             leave OVER, re-enter GRACE
//   i_dino_*              dino box edges (12-bit unsigned)
//   i_obs_*               obstacle edges, slot k at bits [12k+11:12k]
//   i_obs_valid           per-slot presence
//   o_hit                 one-cycle pulse on the game-ending collision
//   o_game_over           level, high while the game is over
//   o_score               survived frames, saturating
//   o_busy                high while the slot scan is in progress
// -----------------------------------------------------------------------------
module collision_detector #(
  parameter int NUM_OBS      = 3,
  parameter int GRACE_FRAMES = 60,
  parameter int SCORE_W      = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_ani_stb,
  input  logic                   i_animate,
  input  logic                   i_restart,
  input  logic [11:0]            i_dino_x1,
  input  logic [11:0]            i_dino_x2,
  input  logic [11:0]            i_dino_y1,
  input  logic [11:0]            i_dino_y2,
  input  logic [12*NUM_OBS-1:0]  i_obs_x1,
  input  logic [12*NUM_OBS-1:0]  i_obs_x2,
  input  logic [12*NUM_OBS-1:0]  i_obs_y1,
  input  logic [12*NUM_OBS-1:0]  i_obs_y2,
  input  logic [NUM_OBS-1:0]     i_obs_valid,
  output logic                   o_hit,
  output logic                   o_game_over,
  output logic [SCORE_W-1:0]     o_score,
  output logic                   o_busy
);

  localparam int         IDX_W      = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam logic [7:0] GRACE_INIT = 8'(GRACE_FRAMES);

  typedef enum logic [1:0] {
    ST_GRACE,
    ST_RUN,
    ST_SCAN,
    ST_OVER
  } state_t;

  state_t             state_reg;
  logic [7:0]         grace_cnt_reg;
  logic [IDX_W-1:0]   idx_reg;

  // Frame snapshot: isolates the scan from input changes after the strobe.
  logic [11:0]           dx1_reg, dx2_reg, dy1_reg, dy2_reg;
  logic [12*NUM_OBS-1:0] ox1_reg, ox2_reg, oy1_reg, oy2_reg;
  logic [NUM_OBS-1:0]    ovalid_reg;

  logic                  qual_stb;
  logic                  last_slot;
  logic                  capture;
  logic [NUM_OBS-1:0]    overlap;

  assign qual_stb  = i_ani_stb && i_animate;
  assign last_slot = (idx_reg == IDX_W'(NUM_OBS - 1));
  assign capture   = (state_reg == ST_RUN) && qual_stb;

  // Per-slot strict overlap on the snapshot. Touching edges do not collide;
  // an absent slot never collides. The scan just picks one bit per clock.
  generate
    for (genvar gi = 0; gi < NUM_OBS; gi++) begin : g_overlap
      assign overlap[gi] = ovalid_reg[gi]
                        && (dx1_reg < ox2_reg[12*gi +: 12])
                        && (ox1_reg[12*gi +: 12] < dx2_reg)
                        && (dy1_reg < oy2_reg[12*gi +: 12])
                        && (oy1_reg[12*gi +: 12] < dy2_reg);
    end
  endgenerate

  // Snapshot data needs no reset; it is only read in SCAN, which is always
  // entered through a capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst && capture) begin
      dx1_reg    <= i_dino_x1;
      dx2_reg    <= i_dino_x2;
      dy1_reg    <= i_dino_y1;
      dy2_reg    <= i_dino_y2;
      ox1_reg    <= i_obs_x1;
      ox2_reg    <= i_obs_x2;
      oy1_reg    <= i_obs_y1;
      oy2_reg    <= i_obs_y2;
      ovalid_reg <= i_obs_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_GRACE;
      grace_cnt_reg <= GRACE_INIT;
      idx_reg       <= '0;
      o_hit         <= 1'b0;
      o_game_over   <= 1'b0;
      o_score       <= '0;
      o_busy        <= 1'b0;
    end else begin
      o_hit <= 1'b0;
      case (state_reg)
        ST_GRACE: begin
          // A zero count (GRACE_FRAMES=0) leaves on the first clock.
          if (grace_cnt_reg == 8'd0) begin
            state_reg <= ST_RUN;
          end else if (qual_stb) begin
            grace_cnt_reg <= grace_cnt_reg - 1'b1;
            if (grace_cnt_reg == 8'd1) begin
              state_reg <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          if (qual_stb) begin
            idx_reg   <= '0;
            o_busy    <= 1'b1;
            state_reg <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (overlap[idx_reg]) begin
            o_hit       <= 1'b1;
            o_game_over <= 1'b1;
            o_busy      <= 1'b0;
            state_reg   <= ST_OVER;
          end else if (last_slot) begin
            o_busy    <= 1'b0;
            state_reg <= ST_RUN;
            if (!(&o_score)) begin
              o_score <= o_score + 1'b1;
            end
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end

        ST_OVER: begin
          if (i_restart) begin
            o_game_over   <= 1'b0;
            o_score       <= '0;
            grace_cnt_reg <= GRACE_INIT;
            state_reg     <= ST_GRACE;
          end
        end

        default: begin
          state_reg <= ST_GRACE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// -----------------------------------------------------------------------------
// tb_collision_detector
//
// Directed stimulus against collision_detector (NUM_OBS=3, GRACE_FRAMES=3,
// SCORE_W=4). A frame-level model predicts the outputs each cycle: on a
// qualifying strobe in play it finds the first colliding slot over the whole
// frame and schedules the outcome. A negedge process compares every cycle.
// Literal checks at key points pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_collision_detector;

  localparam int N    = 3;
  localparam int GF   = 3;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ani_stb = 1'b0;
  logic              animate = 1'b0;
  logic              restart = 1'b0;
  logic [11:0]       dino_x1 = '0, dino_x2 = '0, dino_y1 = '0, dino_y2 = '0;
  logic [12*N-1:0]   obs_x1 = '0, obs_x2 = '0, obs_y1 = '0, obs_y2 = '0;
  logic [N-1:0]      obs_valid = '0;
  logic              hit, game_over, busy;
  logic [SW-1:0]     score;

  int tests  = 0;
  int failed = 0;

  collision_detector #(
    .NUM_OBS(N),
    .GRACE_FRAMES(GF),
    .SCORE_W(SW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ani_stb  (ani_stb),
    .i_animate  (animate),
    .i_restart  (restart),
    .i_dino_x1  (dino_x1),
    .i_dino_x2  (dino_x2),
    .i_dino_y1  (dino_y1),
    .i_dino_y2  (dino_y2),
    .i_obs_x1   (obs_x1),
    .i_obs_x2   (obs_x2),
    .i_obs_y1   (obs_y1),
    .i_obs_y2   (obs_y2),
    .i_obs_valid(obs_valid),
    .o_hit      (hit),
    .o_game_over(game_over),
    .o_score    (score),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  bit m_started = 0;
  bit m_hit = 0, m_over = 0, m_busy = 0, m_in_grace = 1;
  int m_score = 0, m_grace_left = GF, m_elapsed = 0, m_hit_slot = -1;

  // First slot (in scan order) meeting the strict four-edge test, or -1.
  function automatic int first_hit();
    for (int k = 0; k < N; k++) begin
      if (obs_valid[k]
          && dino_x1 < obs_x2[12*k +: 12] && obs_x1[12*k +: 12] < dino_x2
          && dino_y1 < obs_y2[12*k +: 12] && obs_y1[12*k +: 12] < dino_y2)
        return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    m_hit = 0;
    if (rst) begin
      m_started = 1; m_in_grace = 1; m_grace_left = GF;
      m_over = 0; m_score = 0; m_busy = 0;
    end else if (m_over) begin
      if (restart) begin
        m_over = 0; m_score = 0; m_in_grace = 1; m_grace_left = GF;
      end
    end else if (m_busy) begin
      m_elapsed++;
      if (m_hit_slot >= 0 && m_elapsed == m_hit_slot + 1) begin
        m_hit = 1; m_over = 1; m_busy = 0;
      end else if (m_elapsed == N) begin
        m_busy = 0;
        if (m_score < SMAX) m_score++;
      end
    end else if (m_in_grace) begin
      if (m_grace_left == 0) m_in_grace = 0;
      else if (ani_stb && animate) begin
        m_grace_left--;
        if (m_grace_left == 0) m_in_grace = 0;
      end
    end else if (ani_stb && animate) begin
      m_busy = 1; m_elapsed = 0; m_hit_slot = first_hit();
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      cmp("model_hit",       int'(hit),       int'(m_hit));
      cmp("model_game_over", int'(game_over), int'(m_over));
      cmp("model_busy",      int'(busy),      int'(m_busy));
      cmp("model_score",     int'(score),     m_score);
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit anim);
    ani_stb = 1'b1;
    animate = anim;
    tick();
    ani_stb = 1'b0;
    animate = 1'b0;
    $display("[TB] strobe animate=%0d t=%0t score=%0d busy=%0d over=%0d",
             anim, $time, score, busy, game_over);
  endtask

  task automatic set_slot(input int k, input logic [11:0] x1, input logic [11:0] y1,
                          input logic [11:0] x2, input logic [11:0] y2, input bit v);
    obs_x1[12*k +: 12] = x1;
    obs_y1[12*k +: 12] = y1;
    obs_x2[12*k +: 12] = x2;
    obs_y2[12*k +: 12] = y2;
    obs_valid[k]       = v;
  endtask

  task automatic set_dino(input logic [11:0] x1, input logic [11:0] y1,
                          input logic [11:0] x2, input logic [11:0] y2);
    dino_x1 = x1; dino_y1 = y1; dino_x2 = x2; dino_y2 = y2;
  endtask

  task automatic clear_slots();
    for (int k = 0; k < N; k++) set_slot(k, 2000, 2000, 2010, 2010, 1'b1);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    cmp("restart_over", int'(game_over), 0);
    cmp("restart_score", int'(score), 0);
  endtask

  task automatic pass_grace();
    for (int i = 0; i < GF; i++) begin
      strobe(1'b1);
      cmp("grace_no_busy", int'(busy), 0);
      tick();
    end
  endtask

  initial begin
    // --- reset, grace with an overlapping slot 0, then hit at E1
    set_dino(60, 100, 340, 400);
    clear_slots();
    set_slot(0, 100, 130, 380, 400, 1'b1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    cmp("reset_hit", int'(hit), 0);
    cmp("reset_over", int'(game_over), 0);
    cmp("reset_score", int'(score), 0);
    cmp("reset_busy", int'(busy), 0);
    pass_grace();
    strobe(1'b1);                       // E0
    cmp("t1_busy_e0", int'(busy), 1);
    tick();                             // E1
    cmp("t1_hit_e1", int'(hit), 1);
    cmp("t1_over_e1", int'(game_over), 1);
    tick();                             // E2
    cmp("t1_hit_drop", int'(hit), 0);
    cmp("t1_over_hold", int'(game_over), 1);
    do_restart();
    pass_grace();

    // --- hit on slot 1; slot 2 would also collide but is never reached
    clear_slots();
    set_slot(1, 100, 130, 380, 400, 1'b1);
    set_slot(2, 70, 110, 90, 120, 1'b1);
    strobe(1'b1);
    tick();
    cmp("t2_no_hit_e1", int'(hit), 0);
    tick();
    cmp("t2_hit_e2", int'(hit), 1);
    cmp("t2_score", int'(score), 0);
    tick();
    do_restart();
    pass_grace();

    // --- touching edges: clean frame, score +1 at E3
    set_dino(60, 100, 100, 400);
    for (int k = 0; k < N; k++) set_slot(k, 100, 100, 150, 400, 1'b1);
    strobe(1'b1);
    tick(); tick();
    cmp("t3_busy_e2", int'(busy), 1);
    cmp("t3_score_e2", int'(score), 0);
    tick();
    cmp("t3_score_e3", int'(score), 1);
    cmp("t3_busy_e3", int'(busy), 0);
    tick();

    // --- shift slot 0 to x1=99: collides; moving it back after E0 must not matter
    set_slot(0, 99, 100, 150, 400, 1'b1);
    strobe(1'b1);
    set_slot(0, 100, 100, 150, 400, 1'b1);
    tick();
    cmp("t3_shift_hit", int'(hit), 1);
    cmp("t3_shift_score", int'(score), 1);
    tick();
    do_restart();
    pass_grace();

    // --- overlapping but absent slot, then unqualified strobes
    set_dino(60, 100, 340, 400);
    clear_slots();
    set_slot(0, 100, 130, 380, 400, 1'b0);
    strobe(1'b1);
    tick(); tick(); tick();
    cmp("t4_invalid_score", int'(score), 1);
    cmp("t4_invalid_over", int'(game_over), 0);
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0);
      cmp("t4_noanim_busy", int'(busy), 0);
      tick();
    end

    // --- saturation at 15
    clear_slots();
    for (int f = 0; f < 16; f++) begin
      strobe(1'b1);
      tick(); tick(); tick();
    end
    cmp("t5_saturated", int'(score), 15);

    // --- end game, strobe in OVER does nothing, restart clears
    set_slot(0, 100, 130, 380, 400, 1'b1);
    strobe(1'b1);
    tick();
    cmp("t5_hit", int'(hit), 1);
    strobe(1'b1);
    cmp("t5_over_busy", int'(busy), 0);
    cmp("t5_over_score", int'(score), 15);
    tick();
    do_restart();
    pass_grace();

    // --- reset at E1 with an overlap pending on slot 1
    clear_slots();
    set_slot(1, 100, 130, 380, 400, 1'b1);
    strobe(1'b1);                       // E0
    rst = 1'b1;
    tick();                             // E1 samples reset
    rst = 1'b0;
    cmp("t6_hit", int'(hit), 0);
    cmp("t6_over", int'(game_over), 0);
    cmp("t6_busy", int'(busy), 0);
    cmp("t6_score", int'(score), 0);
    tick();
    cmp("t6_late_hit", int'(hit), 0);
    strobe(1'b1);                       // back in grace: no scan
    cmp("t6_grace_busy", int'(busy), 0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
